// File: rtl/ah_write_master_instruction.sv
// ah_write_master_instruction: custom instruction that buffers words into a FIFO and streams them out as Avalon writes
// Ports: clk/reset (sync, active high); dataa/datab/n/start/clk_en -> result/done custom-instruction side;
// master_address/master_write/master_byteenable/master_writedata/master_waitrequest Avalon write-master side.
// Optional feature: define AH_WRITE_COUNT_EN to add a 16-bit completed-transfer counter reported by STATUS.
module ah_write_master_instruction #(
    parameter int M_ADDR_WIDTH    = 24,
    parameter int M_DATA_WIDTH    = 16,
    parameter int BYTEENABLEWIDTH = 2,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                dataa,
    input  logic [31:0]                datab,
    input  logic [1:0]                 n,
    input  logic                       start,
    input  logic                       clk_en,
    output logic [31:0]                result,
    output logic                       done,
    output logic [M_ADDR_WIDTH-1:0]    master_address,
    output logic                       master_write,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    output logic [M_DATA_WIDTH-1:0]    master_writedata,
    input  logic                       master_waitrequest
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] OP_SETBASE = 2'd0;
    localparam logic [1:0] OP_PUSH    = 2'd1;
    localparam logic [1:0] OP_STATUS  = 2'd2;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [31:0]             arg_q, arg_d;
    logic [31:0]             result_q, result_d;
    logic [M_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [AW-1:0]           rd_q, rd_d, wr_q, wr_d;
    logic [M_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                    accept, complete, push, pop, setbase, full, empty;
    logic [15:0]             status_hi;
    logic                    unused_ok;

`ifdef AH_WRITE_COUNT_EN
    logic [15:0] xfer_q, xfer_d;
    always_comb xfer_d = setbase ? 16'h0 : xfer_q + 16'(pop);
    always_ff @(posedge clk) xfer_q <= reset ? 16'h0 : xfer_d;
    assign status_hi = xfer_q;
`else
    assign status_hi = 16'h0;
`endif

    assign unused_ok = ^{datab, arg_q};

    always_comb begin
        full     = count_q == CW'(FIFO_DEPTH);
        empty    = count_q == '0;
        pop      = !empty && !master_waitrequest;
        accept   = state_q == IDLE && start && clk_en;
        // SETBASE and FLUSH both wait for the write stream to drain
        complete = state_q == WAIT && (op_q == OP_PUSH ? !full : op_q == OP_STATUS ? 1'b1 : empty);
        push     = complete && op_q == OP_PUSH;
        setbase  = complete && op_q == OP_SETBASE;
        state_d  = accept ? WAIT : state_q == WAIT ? (complete ? DONE : WAIT) : IDLE;
        op_d     = accept ? n : op_q;
        arg_d    = accept ? dataa : arg_q;
        result_d = complete && op_q == OP_STATUS ? {status_hi, 8'h0, 8'(count_q)} : 32'h0;
        count_d  = count_q + CW'(push) - CW'(pop);
        rd_d     = rd_q + AW'(pop);
        wr_d     = wr_q + AW'(push);
        // setbase requires an empty FIFO, so it can never coincide with a pop
        addr_d   = setbase ? arg_q[M_ADDR_WIDTH-1:0] : pop ? addr_q + M_ADDR_WIDTH'(BYTEENABLEWIDTH) : addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= 2'd0;
            arg_q    <= 32'h0;
            result_q <= 32'h0;
            addr_q   <= '0;
            count_q  <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            arg_q    <= arg_d;
            result_q <= result_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= arg_q[M_DATA_WIDTH-1:0];
    end

    assign result            = result_q;
    assign done              = state_q == DONE;
    assign master_address    = addr_q;
    assign master_write      = !empty;
    assign master_byteenable = '1;
    assign master_writedata  = mem_q[rd_q];
endmodule

// File: doc/ah_write_master_instruction.md
AH_WRITE_MASTER_INSTRUCTION -- requirements
Module: ah_write_master_instruction

Interface
REQ-001 Parameters SHALL be (name, default, meaning): M_ADDR_WIDTH, 24, Avalon byte-address width; M_DATA_WIDTH, 16, write data width; BYTEENABLEWIDTH, 2, byte lanes and address increment per word; FIFO_DEPTH, 8, write buffer depth (power of two, >=2).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Ports SHALL be (name direction width meaning):
  clk  in  1  single clock for the custom-instruction and Avalon sides
  reset  in  1  synchronous active-high reset
  dataa  in  32  operand A: base address or write data
  datab  in  32  operand B: unused, ignored
  n  in  2  operation select: 0 SETBASE, 1 PUSH, 2 STATUS, 3 FLUSH
  start  in  1  one-cycle operation request, qualified by clk_en
  clk_en  in  1  custom-instruction clock enable
  result  out  32  operation result
  done  out  1  one-cycle completion pulse
  master_address  out  M_ADDR_WIDTH  Avalon write address
  master_write  out  1  Avalon write request
  master_byteenable  out  BYTEENABLEWIDTH  always all ones
  master_writedata  out  M_DATA_WIDTH  FIFO head word
  master_waitrequest  in  1  Avalon slave stall

Function
REQ-004 A request SHALL be accepted only when start=1 and clk_en=1 while the instruction FSM is IDLE; start at any other time SHALL be ignored.
REQ-005 Instruction FSM states SHALL be IDLE, WAIT, DONE; IDLE->WAIT on accepted request; WAIT->DONE when the operation's completion condition holds (evaluated first in the cycle after acceptance); DONE->IDLE unconditionally.
REQ-006 done SHALL be 1 for exactly the DONE cycle; result SHALL be valid in that cycle and 0 otherwise.
REQ-007 PUSH completion: FIFO not full; on completion dataa[M_DATA_WIDTH-1:0] SHALL be written to the FIFO tail; result = 0.
REQ-008 SETBASE completion: FIFO empty and master_write=0; on completion the address register SHALL load dataa[M_ADDR_WIDTH-1:0]; result = 0.
REQ-009 FLUSH completion: FIFO empty and master_write=0; result = 0.
REQ-010 STATUS completion: immediate; result[7:0] = FIFO occupancy, other bits per REQ-018/019.
REQ-011 Minimum latency start->done SHALL be 2 cycles (accept, WAIT, DONE); stalls extend WAIT only.
REQ-012 master_write SHALL equal FIFO-not-empty; master_writedata SHALL be the FIFO head; master_byteenable SHALL be all ones.
REQ-013 A transfer completes when master_write=1 and master_waitrequest=0; that cycle SHALL pop the head and add BYTEENABLEWIDTH to the address register.
REQ-014 address/writedata SHALL be held stable while master_write=1 and master_waitrequest=1.
REQ-015 Address addition SHALL wrap modulo 2^M_ADDR_WIDTH.
REQ-016 Simultaneous PUSH completion and pop SHALL both take effect; occupancy unchanged.
REQ-017 A PUSH to a full FIFO SHALL stall in WAIT, completing the cycle after a pop frees space; no data is dropped or overwritten.

Configuration
REQ-018 With AH_WRITE_COUNT_EN defined, a 16-bit completed-transfer counter SHALL increment per REQ-013 transfer (wrapping at 0xFFFF) and appear in STATUS result[31:16]; reset and SETBASE completion clear it.
REQ-019 Without AH_WRITE_COUNT_EN the counter SHALL not exist and STATUS result[31:8] SHALL be 0.

Reset
REQ-020 Reset SHALL force instruction FSM IDLE, FIFO empty, address 0, counter 0, done 0, result 0, master_write 0, and SHALL discard buffered data, including mid-stall or mid-transfer; reset dominates start.

Verification
REQ-021 SETBASE 0x000100, PUSH 0x1111, 0x2222, waitrequest=0 -> writes 0x1111@0x000100, 0x2222@0x000102; each done 2 cycles after start.
REQ-022 waitrequest=1 for 5 cycles during first write -> address/data held 5 cycles, one write only, no pop.
REQ-023 waitrequest=1, 9 PUSHes -> 8 complete, 9th stalls; release waitrequest -> 9th completes after first pop, all 9 words written in order.
REQ-024 SETBASE 0xFFFFFE, PUSH A, B -> writes at 0xFFFFFE then 0x000000.
REQ-025 FLUSH with 3 words pending -> done only after 3rd transfer; STATUS then returns occupancy 0 (with AH_WRITE_COUNT_EN, result[31:16]=3).
REQ-026 Reset asserted during stalled PUSH with full FIFO -> next cycle master_write=0, done=0, STATUS occupancy 0.
